// File: rtl/idft8_serial_if.sv
// Complex-sample valid/ready stream.
//   valid  : producer has a sample
//   ready  : consumer accepts a sample
//   re, im : signed real / imaginary parts, DW bits each
//   last   : marks the final sample of a frame
// master = producer side, slave = consumer side.
interface idft8_serial_if #(
  parameter int unsigned DW = 16
);
  logic                 valid;
  logic                 ready;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic                 last;

  modport master (output valid, re, im, last, input ready);
  modport slave  (input valid, re, im, last, output ready);
endinterface

// File: rtl/idft8_serial.sv
// Serial 8-point inverse DFT, one complex MAC per cycle.
// Loads eight bins Z0..Z7 (sfix 12.4), then for each n=0..7 accumulates
// sum_k Z[k]*e^(+j2*pi*n*k/8) over 8 cycles and emits x[n] = acc >>> 7, saturated.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   in_s   : bin stream in (valid/ready/re/im; last is ignored)
//   out_m  : sample stream out (valid/ready/re/im; last high with x7)
module idft8_serial #(
  parameter int unsigned DW   = 16,
  parameter int unsigned ACCW = 26
) (
  input logic             clk,
  input logic             rst,
  idft8_serial_if.slave   in_s,
  idft8_serial_if.master  out_m
);

  // Twiddles are 6-bit signed (range -16..16); products need DW+6 bits.
  localparam int unsigned PW = DW + 6;
  localparam logic signed [ACCW-1:0] SatMax = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SatMin = -SatMax - ACCW'(1);

  typedef enum logic [1:0] {StLoad, StCalc, StEmit} state_e;

  state_e state_q, state_d;

  logic [2:0] kcnt_q, n_q, k_q;
  logic signed [ACCW-1:0] acc_re_q, acc_im_q;
  logic signed [DW-1:0] out_re_q, out_im_q;
  logic signed [DW-1:0] buf_re_q [8];
  logic signed [DW-1:0] buf_im_q [8];

  logic in_ready, out_valid, out_last;
  logic in_fire, out_fire;

  assign in_fire  = in_s.valid & in_ready;
  assign out_fire = out_valid & out_m.ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StLoad;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (in_fire && kcnt_q == 3'd7) state_d = StCalc;
      StCalc: if (k_q == 3'd7) state_d = StEmit;
      StEmit: if (out_fire) state_d = (n_q == 3'd7) ? StLoad : StCalc;
      default: state_d = StLoad;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StEmit);
    out_last  = (state_q == StEmit) && (n_q == 3'd7);
  end

  assign in_s.ready  = in_ready;
  assign out_m.valid = out_valid;
  assign out_m.last  = out_last;
  assign out_m.re    = out_re_q;
  assign out_m.im    = out_im_q;

  // ---------------------------------------------------------------------------
  // Twiddle lookup: m = (n*k) mod 8, truncation of the 3-bit product.
  logic [2:0] m;
  logic signed [5:0] cos_w, sin_w;

  assign m = 3'(n_q * k_q);

  always_comb begin
    cos_w = 6'sd0;
    sin_w = 6'sd0;
    unique case (m)
      3'd0: begin cos_w =  6'sd16; sin_w =  6'sd0;  end
      3'd1: begin cos_w =  6'sd11; sin_w =  6'sd11; end
      3'd2: begin cos_w =  6'sd0;  sin_w =  6'sd16; end
      3'd3: begin cos_w = -6'sd11; sin_w =  6'sd11; end
      3'd4: begin cos_w = -6'sd16; sin_w =  6'sd0;  end
      3'd5: begin cos_w = -6'sd11; sin_w = -6'sd11; end
      3'd6: begin cos_w =  6'sd0;  sin_w = -6'sd16; end
      3'd7: begin cos_w =  6'sd11; sin_w = -6'sd11; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Complex MAC datapath
  logic signed [PW-1:0]   zr_x, zi_x, c_x, s_x;
  logic signed [PW-1:0]   p_rc, p_is, p_rs, p_ic;
  logic signed [PW:0]     mac_re, mac_im;
  logic signed [ACCW-1:0] acc_re_nx, acc_im_nx;

  always_comb begin
    zr_x      = PW'(buf_re_q[k_q]);
    zi_x      = PW'(buf_im_q[k_q]);
    c_x       = PW'(cos_w);
    s_x       = PW'(sin_w);
    p_rc      = zr_x * c_x;
    p_is      = zi_x * s_x;
    p_rs      = zr_x * s_x;
    p_ic      = zi_x * c_x;
    mac_re    = (PW + 1)'(p_rc) - (PW + 1)'(p_is);
    mac_im    = (PW + 1)'(p_rs) + (PW + 1)'(p_ic);
    acc_re_nx = acc_re_q + ACCW'(mac_re);
    acc_im_nx = acc_im_q + ACCW'(mac_im);
  end

  // >>> 7 drops the 4 twiddle fraction bits and applies the 1/8 scale (floor).
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> 7;
    if (s > SatMax)      return SatMax[DW-1:0];
    else if (s < SatMin) return SatMin[DW-1:0];
    else                 return s[DW-1:0];
  endfunction

  // Bin buffer: no reset needed, it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re_q[kcnt_q] <= in_s.re;
      buf_im_q[kcnt_q] <= in_s.im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt_q   <= 3'd0;
      n_q      <= 3'd0;
      k_q      <= 3'd0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            kcnt_q <= kcnt_q + 3'd1;
            if (kcnt_q == 3'd7) begin
              n_q      <= 3'd0;
              k_q      <= 3'd0;
              acc_re_q <= '0;
              acc_im_q <= '0;
            end
          end
        end
        StCalc: begin
          k_q      <= k_q + 3'd1;
          acc_re_q <= acc_re_nx;
          acc_im_q <= acc_im_nx;
          if (k_q == 3'd7) begin
            out_re_q <= scale_sat(acc_re_nx);
            out_im_q <= scale_sat(acc_im_nx);
          end
        end
        StEmit: begin
          if (out_fire) begin
            k_q      <= 3'd0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            n_q      <= n_q + 3'd1;
            if (n_q == 3'd7) kcnt_q <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idft8_serial.sv
// Directed bench for idft8_serial: impulse, flat, single tone, saturation,
// output backpressure, input gaps and reset during computation.
module tb_idft8_serial;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  idft8_serial_if #(.DW(DW)) in_if ();
  idft8_serial_if #(.DW(DW)) out_if ();

  idft8_serial #(
    .DW  (16),
    .ACCW(26)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in_s (in_if),
    .out_m(out_if)
  );

  int tests = 0;
  int fails = 0;
  int fr_re[8], fr_im[8];
  int ex_re[8], ex_im[8];

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds fr_re/fr_im; optionally drops in_valid for gap cycles before bin 4.
  // Returns just after the edge on which bin 7 transferred.
  task automatic send_frame(input int gap);
    for (int k = 0; k < 8; k++) begin
      if (k == 4 && gap > 0) begin
        in_if.valid = 1'b0;
        repeat (gap) tick();
        chk("gap_in_ready", int'(in_if.ready), 1);
      end
      in_if.valid = 1'b1;
      in_if.re    = DW'(fr_re[k]);
      in_if.im    = DW'(fr_im[k]);
      begin
        int cnt = 0;
        while (in_if.ready !== 1'b1 && cnt < 200) begin
          tick();
          cnt++;
        end
        if (in_if.ready !== 1'b1) chk($sformatf("bin%0d_timeout", k), 0, 1);
      end
      tick();
    end
    in_if.valid = 1'b0;
    in_if.re    = '0;
    in_if.im    = '0;
  endtask

  // Waits for sample n, checks it, optionally stalls, then transfers it.
  task automatic recv_sample(input int n, input bit check_data, input int stall);
    int cnt = 0;
    if (stall > 0) out_if.ready = 1'b0;
    while (out_if.valid !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    if (out_if.valid !== 1'b1) begin
      chk($sformatf("x%0d_timeout", n), 0, 1);
      out_if.ready = 1'b1;
      return;
    end
    if (check_data) begin
      chk($sformatf("x%0d_re", n), int'($signed(out_if.re)), ex_re[n]);
      chk($sformatf("x%0d_im", n), int'($signed(out_if.im)), ex_im[n]);
    end
    chk($sformatf("x%0d_last", n), int'(out_if.last), (n == 7) ? 1 : 0);
    chk($sformatf("x%0d_in_ready", n), int'(in_if.ready), 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), int'(out_if.valid), 1);
      if (check_data) begin
        chk($sformatf("stall%0d_re", i), int'($signed(out_if.re)), ex_re[n]);
        chk($sformatf("stall%0d_im", i), int'($signed(out_if.im)), ex_im[n]);
      end
    end
    out_if.ready = 1'b1;
    tick();
  endtask

  task automatic recv_frame(input int stall_n, input int stall);
    for (int n = 0; n < 8; n++) recv_sample(n, 1'b1, (n == stall_n) ? stall : 0);
    chk("frame_done_valid", int'(out_if.valid), 0);
    chk("frame_done_in_ready", int'(in_if.ready), 1);
  endtask

  initial begin
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.re     = '0;
    in_if.im     = '0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", int'(in_if.ready), 1);
    chk("rst_out_valid", int'(out_if.valid), 0);
    chk("rst_out_last", int'(out_if.last), 0);
    chk("rst_out_re", int'($signed(out_if.re)), 0);
    chk("rst_out_im", int'($signed(out_if.im)), 0);
    rst = 1'b0;

    // Impulse with exact latency check: x0 valid after edge E+8.
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = (k == 0) ? 128 : 0;
      fr_im[k] = 0;
      ex_re[k] = 16;
      ex_im[k] = 0;
    end
    send_frame(0);
    chk("lat_e0_valid", int'(out_if.valid), 0);
    repeat (7) tick();
    chk("lat_e7_valid", int'(out_if.valid), 0);
    tick();
    chk("lat_e8_valid", int'(out_if.valid), 1);
    recv_frame(-1, 0);

    // Flat spectrum, with an in_valid gap mid-load.
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 128;
      fr_im[k] = 0;
      ex_re[k] = (k == 0) ? 128 : 0;
      ex_im[k] = 0;
    end
    send_frame(3);
    recv_frame(-1, 0);

    // Single tone Z1=128 with 5-cycle stall on x2.
    ex_re = '{16, 11, 0, -11, -16, -11, 0, 11};
    ex_im = '{0, 11, 16, 11, 0, -11, -16, -11};
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = (k == 1) ? 128 : 0;
      fr_im[k] = 0;
    end
    send_frame(0);
    recv_frame(2, 5);

    // Second frame back-to-back: impulse.
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = (k == 0) ? 128 : 0;
      fr_im[k] = 0;
      ex_re[k] = 16;
      ex_im[k] = 0;
    end
    send_frame(0);
    recv_frame(-1, 0);

    // Saturation: x0 floors to -1-j1, x1 re saturates (38911 -> 32767), im 0.
    fr_re = '{32767, 32767, 0, -32768, -32768, -32768, 0, 32767};
    fr_im = '{0, -32768, -32768, -32768, 0, 32767, 32767, 32767};
    ex_re[0] = -1;
    ex_im[0] = -1;
    ex_re[1] = 32767;
    ex_im[1] = 0;
    send_frame(0);
    recv_sample(0, 1'b1, 0);
    recv_sample(1, 1'b1, 0);
    for (int n = 2; n < 8; n++) recv_sample(n, 1'b0, 0);
    chk("sat_done_in_ready", int'(in_if.ready), 1);

    // Reset during CALC of x3.
    ex_re = '{16, 11, 0, -11, -16, -11, 0, 11};
    ex_im = '{0, 11, 16, 11, 0, -11, -16, -11};
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = (k == 1) ? 128 : 0;
      fr_im[k] = 0;
    end
    send_frame(0);
    for (int n = 0; n < 3; n++) recv_sample(n, 1'b1, 0);
    tick();
    tick();
    chk("pre_rst_valid", int'(out_if.valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_if.valid), 0);
    chk("midrst_out_re", int'($signed(out_if.re)), 0);
    chk("midrst_out_im", int'($signed(out_if.im)), 0);
    chk("midrst_in_ready", int'(in_if.ready), 1);

    for (int k = 0; k < 8; k++) begin
      fr_re[k] = (k == 0) ? 128 : 0;
      fr_im[k] = 0;
      ex_re[k] = 16;
      ex_im[k] = 0;
    end
    send_frame(0);
    recv_frame(-1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idft8_serial.md
# idft8_serial

Serial 8-point inverse DFT, the inverse of the team's combinational 8-point radix-2 forward transform. Accepts one frame of eight complex frequency bins Z0..Z7 over a valid/ready stream, stores it, and computes x[n] = (1/8)·Σk Z[k]·e^(+j2πnk/8) with one complex multiply-accumulate per cycle. It emits the eight complex time samples x0..x7 on a second valid/ready stream. It sits after the spectral-processing stage and returns data to the sample domain.

## Interface
- DW, 16, bin and sample width; signed, 4 fractional bits (sfix 12.4)
- ACCW, 26, accumulator width; signed, 8 fractional bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  bin present
- in_ready  out  1  block accepts a bin
- in_re, in_im  in  DW each  bin Z[k]; bins arrive in order k=0..7
- out_valid  out  1  sample present
- out_ready  in  1  sink accepts a sample
- out_re, out_im  out  DW each  sample x[n], emitted in order n=0..7
- out_last  out  1  high with x7

## Operation
- Handshakes:
  - Transfer on a rising edge with valid&ready.
  - Once out_valid rises, out_re, out_im and out_last are held stable until the transfer.
- States: LOAD, CALC, EMIT.
  - **LOAD**: in_ready=1. Each transfer writes the bin to buf[kcnt] and increments kcnt. When the transfer at kcnt=7 occurs, go to CALC with n=0, k=0 and both accumulators cleared.
  - **CALC**: in_ready=0, out_valid=0. Each cycle performs one complex MAC for the current k, then k++. After the k=7 MAC, register the result into out_re/out_im and go to EMIT.
  - **EMIT**: out_valid=1. On transfer:
    - if n<7: n++, clear k and the accumulators, go to CALC.
    - if n=7: go to LOAD with kcnt=0.
- Twiddle index: m = (n·k) mod 8, i.e. the low 3 bits of n·k.
  - cos[m] = 16, 11, 0, −11, −16, −11, 0, 11
  - sin[m] = 0, 11, 16, 11, 0, −11, −16, −11
  - Both are sfix with 4 fractional bits, matching the forward transform's 11/16 approximation of √2/2.
- MAC step:
  - acc_re += Zr·cos − Zi·sin
  - acc_im += Zr·sin + Zi·cos
  - Products are full-precision signed. ACCW is sufficient: |acc| ≤ 8·32768·27 < 2^25.
- Output scaling: result = acc >>> 7, an arithmetic shift that removes 4 twiddle fractional bits and applies the 1/8 scale (floor rounding). The result then saturates to [−32768, 32767].
- No input is accepted outside LOAD. Bins offered early simply wait under in_ready=0.

## Timing
- Reset values:
  - state=LOAD, kcnt=n=k=0, accumulators=0
  - in_ready=1 in the first cycle after reset
  - out_valid=0, out_last=0, out_re=out_im=0
- Latency: if bin 7 transfers at edge E, out_valid for x0 is high in the cycle after edge E+8 (8 CALC cycles).
- Each subsequent sample takes 8 CALC cycles after the previous sample's output transfer.
- Minimum frame period: 8 load + 8×(8+1) = 80 cycles.
- out_ready held low: the FSM stalls in EMIT indefinitely and data stays unchanged.
- out_ready already high when out_valid rises: the transfer happens on the first EMIT edge.
- rst asserted in any state, including mid-LOAD or mid-CALC: the partial frame is discarded and all registers return to their reset values on that edge. rst has priority over a simultaneous handshake.
- in_valid dropping mid-frame: LOAD waits, and kcnt is preserved.

## Test plan
- Impulse: Z0=128 (8.0), Z1..Z7=0, out_ready=1 → x0..x7 all equal 16+j0; out_last is high only on x7; the x0 latency is exactly 8 cycles after the bin-7 edge.
- Flat spectrum: all Z=128+j0 → x0=128+j0 and x1..x7=0+j0.
- Single tone: Z1=128, others 0 → the outputs are, in order:
  - x0..x3: 16+j0, 11+j11, 0+j16, −11+j11
  - x4..x7: −16+j0, −11−j11, 0−j16, 11−j11
- Saturation:
  - Input frame:
    - re = 32767, 32767, 0, −32768, −32768, −32768, 0, 32767
    - im = 0, −32768, −32768, −32768, 0, 32767, 32767, 32767
  - Required response: the unsaturated acc_re for x1 is 4980660 (4980660 >>> 7 = 38911), so out_re for x1 = 32767.
- Backpressure and stall:
  - Single-tone frame with out_ready low for 5 cycles while x2 is presented → out_valid stays high and x2 = 0+j16 is held unchanged; all 8 samples arrive with none lost or duplicated.
  - in_ready stays 0 until x7 transfers.
  - A second frame fed back-to-back then produces correct results.
- Reset mid-operation: assert rst for one cycle during CALC of x3 → in the next cycle out_valid=0, out_re=out_im=0 and in_ready=1. A fresh impulse frame then yields eight samples of 16+j0.
